// File: rtl/thor2023_memreq_tracker_pkg.sv
// Shared types for the Thor2023 outstanding-memory-request tracker.
// THOR2023_MEMREQ_TRACKER_TIMEOUT_EN adds a per-slot response timer to the slot record.
package Thor2023Pkg;

    // Widest payload a slot can hold; the tracker's DATAW/TGTW must not exceed these.
    localparam int unsigned MEMTRK_DATAW = 96;
    localparam int unsigned MEMTRK_TGTW  = 7;
    localparam int unsigned MEMTRK_TMRW  = 16;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } memtrk_state_t;

    typedef struct packed {
        memtrk_state_t            state;
        logic                     load;
        logic [MEMTRK_TGTW-1:0]   tgt;
        logic [MEMTRK_DATAW-1:0]  res;
        logic                     err;
`ifdef THOR2023_MEMREQ_TRACKER_TIMEOUT_EN
        logic [MEMTRK_TMRW-1:0]   timer;
`endif
    } memtrk_entry_t;

endpackage

// File: rtl/thor2023_memreq_tracker_if.sv
// Sequencer/BIU/writeback signal bundle of the memory-request tracker.
// The slave modport is the tracker; the master modport is its environment.
interface thor2023_memreq_tracker_if #(
    parameter int unsigned TIDW  = 8,
    parameter int unsigned DATAW = 96,
    parameter int unsigned TGTW  = 7
) ();

    logic             alloc_v_i;
    logic             alloc_rdy_o;
    logic             alloc_load_i;
    logic [TGTW-1:0]  alloc_tgt_i;
    logic [TIDW-1:0]  alloc_tid_o;

    logic             rsp_v_i;
    logic [TIDW-1:0]  rsp_tid_i;
    logic [DATAW-1:0] rsp_res_i;
    logic             rsp_err_i;

    logic             ret_v_o;
    logic             ret_rdy_i;
    logic             ret_load_o;
    logic [TGTW-1:0]  ret_tgt_o;
    logic [DATAW-1:0] ret_res_o;
    logic             ret_err_o;
    logic [TIDW-1:0]  ret_tid_o;

    modport slave (
        input  alloc_v_i, alloc_load_i, alloc_tgt_i,
        output alloc_rdy_o, alloc_tid_o,
        input  rsp_v_i, rsp_tid_i, rsp_res_i, rsp_err_i,
        output ret_v_o, ret_load_o, ret_tgt_o, ret_res_o, ret_err_o, ret_tid_o,
        input  ret_rdy_i
    );

    modport master (
        output alloc_v_i, alloc_load_i, alloc_tgt_i,
        input  alloc_rdy_o, alloc_tid_o,
        output rsp_v_i, rsp_tid_i, rsp_res_i, rsp_err_i,
        input  ret_v_o, ret_load_o, ret_tgt_o, ret_res_o, ret_err_o, ret_tid_o,
        output ret_rdy_i
    );

endinterface

// File: rtl/thor2023_memreq_tracker_slot.sv
// One tracker slot: FREE -> PEND on alloc, PEND -> DONE on response, DONE -> FREE on retire.
// With THOR2023_MEMREQ_TRACKER_TIMEOUT_EN a PEND slot self-completes with err=1 after TIMEOUT cycles.
module thor2023_memreq_tracker_slot
    import Thor2023Pkg::*;
`ifdef THOR2023_MEMREQ_TRACKER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT = 1023
)
`endif
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    alloc_i,
    input  logic                    load_i,
    input  logic [MEMTRK_TGTW-1:0]  tgt_i,
    input  logic                    complete_i,
    input  logic [MEMTRK_DATAW-1:0] res_i,
    input  logic                    err_i,
    input  logic                    free_i,
    output memtrk_entry_t           entry_o
);

    memtrk_entry_t entry_q, entry_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = '0;
        end else if (alloc_i) begin
            entry_d       = '0;
            entry_d.state = PEND;
            entry_d.load  = load_i;
            entry_d.tgt   = tgt_i;
        end else if (complete_i) begin
            entry_d.state = DONE;
            entry_d.res   = res_i;
            entry_d.err   = err_i;
        end else if (free_i) begin
            entry_d.state = FREE;
`ifdef THOR2023_MEMREQ_TRACKER_TIMEOUT_EN
        end else if (entry_q.state == PEND) begin
            if (entry_q.timer == MEMTRK_TMRW'(TIMEOUT)) begin
                entry_d.state = DONE;
                entry_d.err   = 1'b1;
                entry_d.res   = '0;
            end else begin
                entry_d.timer = entry_q.timer + 1'b1;
            end
`endif
        end
    end

    // NOTE: the payload is reset along with the state because the head slot's fields drive ret_* directly.
    // NOTE: state flops use non-blocking assignments so every slot samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/thor2023_memreq_tracker.sv
// Out-of-order-completion, in-order-retire tracker for up to DEPTH outstanding memory requests.
// Define THOR2023_MEMREQ_TRACKER_TIMEOUT_EN to enable per-slot response timeouts (TIMEOUT cycles).
module thor2023_memreq_tracker
    import Thor2023Pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIDW    = 8,
    parameter int unsigned DATAW   = MEMTRK_DATAW,
    parameter int unsigned TGTW    = MEMTRK_TGTW,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    thor2023_memreq_tracker_if.slave bus,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     stray_o
);

    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned EPW  = TIDW - IDXW;
    localparam int unsigned CNTW = IDXW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIDW < IDXW + 1 ||
        DATAW > MEMTRK_DATAW || TGTW > MEMTRK_TGTW || TIMEOUT == 0 ||
        TIMEOUT >= (1 << MEMTRK_TMRW)) begin : g_bad_params
        $error("thor2023_memreq_tracker: illegal parameter combination");
    end

    memtrk_entry_t   slots [DEPTH];
    logic [DEPTH-1:0] alloc_s, complete_s, free_s;

    logic [IDXW-1:0] head_q, head_d, tail_q, tail_d;
    logic [EPW-1:0]  epoch_q, epoch_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            stray_q, stray_d;

    logic [IDXW-1:0] rsp_idx;
    logic [EPW-1:0]  rsp_ep;
    logic            alloc_fire, rsp_hit, ret_fire;

    assign rsp_idx = bus.rsp_tid_i[IDXW-1:0];
    assign rsp_ep  = bus.rsp_tid_i[TIDW-1:IDXW];

    // Flush masks allocation here, so alloc_fire already implies no flush.
    assign bus.alloc_rdy_o = (count_q < CNTW'(DEPTH)) && !flush_i;
    assign bus.alloc_tid_o = {epoch_q, tail_q};
    assign alloc_fire      = bus.alloc_v_i && bus.alloc_rdy_o;

    assign rsp_hit  = bus.rsp_v_i && !flush_i && (slots[rsp_idx].state == PEND) && (rsp_ep == epoch_q);
    assign ret_fire = bus.ret_v_o && bus.ret_rdy_i;

    assign bus.ret_v_o    = (slots[head_q].state == DONE);
    assign bus.ret_load_o = slots[head_q].load;
    assign bus.ret_tgt_o  = slots[head_q].tgt[TGTW-1:0];
    assign bus.ret_res_o  = slots[head_q].res[DATAW-1:0];
    assign bus.ret_err_o  = slots[head_q].err;
    assign bus.ret_tid_o  = {epoch_q, head_q};

    always_comb begin
        alloc_s    = '0;
        complete_s = '0;
        free_s     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alloc_s[i]    = alloc_fire && (tail_q == IDXW'(i));
            complete_s[i] = rsp_hit && (rsp_idx == IDXW'(i));
            free_s[i]     = ret_fire && (head_q == IDXW'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        thor2023_memreq_tracker_slot
`ifdef THOR2023_MEMREQ_TRACKER_TIMEOUT_EN
            #(.TIMEOUT(TIMEOUT))
`endif
            u_slot (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .flush_i    (flush_i),
                .alloc_i    (alloc_s[g]),
                .load_i     (bus.alloc_load_i),
                .tgt_i      (MEMTRK_TGTW'(bus.alloc_tgt_i)),
                .complete_i (complete_s[g]),
                .res_i      (MEMTRK_DATAW'(bus.rsp_res_i)),
                .err_i      (bus.rsp_err_i),
                .free_i     (free_s[g]),
                .entry_o    (slots[g])
            );
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        epoch_d = epoch_q;
        stray_d = 1'b0;
        if (flush_i) begin
            // A response arriving with the flush is discarded silently, not reported as stray.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            epoch_d = epoch_q + 1'b1;
        end else begin
            if (alloc_fire) tail_d = tail_q + 1'b1;
            if (ret_fire)   head_d = head_q + 1'b1;
            count_d = count_q + CNTW'(alloc_fire) - CNTW'(ret_fire);
            stray_d = bus.rsp_v_i && !rsp_hit;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            epoch_q <= '0;
            stray_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            epoch_q <= epoch_d;
            stray_q <= stray_d;
        end
    end

    assign count_o = count_q;
    assign stray_o = stray_q;

endmodule

// File: tb/tb_thor2023_memreq_tracker.sv
// Directed bench for thor2023_memreq_tracker (DEPTH=4, TIDW=8); expected values are hand-computed.
// The timeout step runs only when THOR2023_MEMREQ_TRACKER_TIMEOUT_EN is defined (TIMEOUT=15).
module tb_thor2023_memreq_tracker;

`ifdef THOR2023_MEMREQ_TRACKER_TIMEOUT_EN
    localparam int unsigned TMO = 15;
`else
    localparam int unsigned TMO = 1023;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [2:0] count;
    logic       stray;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    thor2023_memreq_tracker_if #(.TIDW(8), .DATAW(96), .TGTW(7)) bus ();

    thor2023_memreq_tracker #(
        .DEPTH(4), .TIDW(8), .DATAW(96), .TGTW(7), .TIMEOUT(TMO)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus),
        .count_o (count),
        .stray_o (stray)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge; inputs change and outputs are sampled there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic v, input logic [6:0] tgt);
        bus.alloc_v_i    = v;
        bus.alloc_load_i = v;
        bus.alloc_tgt_i  = tgt;
    endtask

    task automatic set_rsp(input logic v, input logic [7:0] tid, input logic [95:0] res, input logic err);
        bus.rsp_v_i   = v;
        bus.rsp_tid_i = tid;
        bus.rsp_res_i = res;
        bus.rsp_err_i = err;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        set_alloc(1'b0, 7'd0);
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        bus.ret_rdy_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_alloc_rdy", bus.alloc_rdy_o, 1);
        check("rst_alloc_tid", bus.alloc_tid_o, 8'h00);
        check("rst_ret_v",     bus.ret_v_o, 0);
        check("rst_ret_res",   bus.ret_res_o, 96'h0);
        check("rst_ret_tgt",   bus.ret_tgt_o, 7'h0);
        check("rst_ret_tid",   bus.ret_tid_o, 8'h00);
        check("rst_count",     count, 3'd0);
        check("rst_stray",     stray, 0);

        // Fill all four slots: tids 0..3
        for (int i = 0; i < 4; i++) begin
            set_alloc(1'b1, 7'(i + 1));
            #1;
            check($sformatf("fill_tid%0d", i), bus.alloc_tid_o, 8'(i));
            check($sformatf("fill_rdy%0d", i), bus.alloc_rdy_o, 1);
            tick();
            if (i == 0) check("count_after_first_alloc", count, 3'd1);
        end
        set_alloc(1'b0, 7'd0);
        check("full_count", count, 3'd4);
        check("full_alloc_rdy", bus.alloc_rdy_o, 0);

        // Out-of-order responses 2,0,3,1; in-order retire
        bus.ret_rdy_i = 1'b1;
        set_rsp(1'b1, 8'h02, 96'hA2, 1'b0);
        tick();
        check("ooo_head_pending", bus.ret_v_o, 0);
        set_rsp(1'b1, 8'h00, 96'hA0, 1'b0);
        tick();
        check("ret0_v",    bus.ret_v_o, 1);
        check("ret0_tid",  bus.ret_tid_o, 8'h00);
        check("ret0_res",  bus.ret_res_o, 96'hA0);
        check("ret0_tgt",  bus.ret_tgt_o, 7'd1);
        check("ret0_load", bus.ret_load_o, 1);
        set_rsp(1'b1, 8'h03, 96'hA3, 1'b0);
        tick();
        check("head1_pending", bus.ret_v_o, 0);
        check("count_after_ret0", count, 3'd3);
        set_rsp(1'b1, 8'h01, 96'hA1, 1'b0);
        tick();
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        check("ret1_v",   bus.ret_v_o, 1);
        check("ret1_tid", bus.ret_tid_o, 8'h01);
        check("ret1_res", bus.ret_res_o, 96'hA1);
        tick();
        check("ret2_tid", bus.ret_tid_o, 8'h02);
        check("ret2_res", bus.ret_res_o, 96'hA2);
        tick();
        check("ret3_tid", bus.ret_tid_o, 8'h03);
        check("ret3_res", bus.ret_res_o, 96'hA3);
        check("ret3_tgt", bus.ret_tgt_o, 7'd4);
        tick();
        check("drained_ret_v", bus.ret_v_o, 0);
        check("drained_count", count, 3'd0);

        // Two allocations, flush, then late responses become strays
        set_alloc(1'b1, 7'd9);
        #1;
        check("wrap_tid0", bus.alloc_tid_o, 8'h00);
        tick();
        check("wrap_tid1", bus.alloc_tid_o, 8'h01);
        tick();
        set_alloc(1'b0, 7'd0);
        check("pre_flush_count", count, 3'd2);
        flush = 1'b1;
        #1;
        check("flush_blocks_alloc", bus.alloc_rdy_o, 0);
        tick();
        flush = 1'b0;
        check("post_flush_count", count, 3'd0);
        check("post_flush_tid", bus.alloc_tid_o, 8'h04);
        set_rsp(1'b1, 8'h00, 96'hDEAD, 1'b0);
        tick();
        check("stray_a", stray, 1);
        check("stray_a_ret_v", bus.ret_v_o, 0);
        set_rsp(1'b1, 8'h01, 96'hBEEF, 1'b0);
        tick();
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        check("stray_b", stray, 1);
        check("stray_b_ret_v", bus.ret_v_o, 0);
        tick();
        check("stray_pulse_ends", stray, 0);
        check("stray_count", count, 3'd0);

        // New epoch allocation, faulted response
        set_alloc(1'b1, 7'd5);
        #1;
        check("epoch1_tid", bus.alloc_tid_o, 8'h04);
        tick();
        set_alloc(1'b0, 7'd0);
        set_rsp(1'b1, 8'h04, 96'h55, 1'b1);
        tick();
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        check("e1_ret_v",   bus.ret_v_o, 1);
        check("e1_ret_err", bus.ret_err_o, 1);
        check("e1_ret_tid", bus.ret_tid_o, 8'h04);
        check("e1_ret_res", bus.ret_res_o, 96'h55);
        tick();
        check("e1_retired_count", count, 3'd0);

        // Full tracker: retire and allocate in one cycle -> allocation refused, taken next cycle
        bus.ret_rdy_i = 1'b0;
        set_alloc(1'b1, 7'd7);
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("e1_fill_tid%0d", i), bus.alloc_tid_o, 8'h04 + 8'((i + 1) % 4));
            tick();
        end
        set_alloc(1'b0, 7'd0);
        check("e1_full_count", count, 3'd4);
        set_rsp(1'b1, 8'h05, 96'hB5, 1'b0);
        tick();
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        check("e1_head_v",   bus.ret_v_o, 1);
        check("e1_head_tid", bus.ret_tid_o, 8'h05);
        tick();
        check("hold_ret_v",   bus.ret_v_o, 1);
        check("hold_ret_res", bus.ret_res_o, 96'hB5);
        bus.ret_rdy_i = 1'b1;
        set_alloc(1'b1, 7'd3);
        #1;
        check("no_bypass_rdy", bus.alloc_rdy_o, 0);
        tick();
        bus.ret_rdy_i = 1'b0;
        check("after_retire_count", count, 3'd3);
        check("after_retire_rdy", bus.alloc_rdy_o, 1);
        check("after_retire_tid", bus.alloc_tid_o, 8'h05);
        tick();
        set_alloc(1'b0, 7'd0);
        check("refill_count", count, 3'd4);
        check("refill_rdy", bus.alloc_rdy_o, 0);

        // Flush together with a valid response: flush wins, no stray
        flush = 1'b1;
        set_rsp(1'b1, 8'h06, 96'hC6, 1'b0);
        tick();
        flush = 1'b0;
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        check("flush_rsp_no_stray", stray, 0);
        check("flush_rsp_count", count, 3'd0);
        check("flush_rsp_ret_v", bus.ret_v_o, 0);
        check("epoch2_tid", bus.alloc_tid_o, 8'h08);

        // Reset mid-operation returns epoch to 0
        set_alloc(1'b1, 7'd2);
        tick();
        set_alloc(1'b0, 7'd0);
        check("pre_rst_count", count, 3'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", count, 3'd0);
        check("mid_rst_tid", bus.alloc_tid_o, 8'h00);

        // Response to a FREE slot
        set_rsp(1'b1, 8'h02, 96'h77, 1'b0);
        tick();
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        check("free_slot_stray", stray, 1);
        check("free_slot_count", count, 3'd0);
        check("free_slot_ret_v", bus.ret_v_o, 0);

`ifdef THOR2023_MEMREQ_TRACKER_TIMEOUT_EN
        // Unanswered request times out 16 cycles after allocation
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        set_alloc(1'b1, 7'd6);
        tick();
        set_alloc(1'b0, 7'd0);
        for (int i = 0; i < 15; i++) tick();
        check("tmo_not_yet", bus.ret_v_o, 0);
        tick();
        check("tmo_ret_v",   bus.ret_v_o, 1);
        check("tmo_ret_err", bus.ret_err_o, 1);
        check("tmo_ret_res", bus.ret_res_o, 96'h0);
        set_rsp(1'b1, 8'h00, 96'h99, 1'b0);
        tick();
        set_rsp(1'b0, 8'h00, 96'h0, 1'b0);
        check("tmo_late_stray", stray, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
